// File: rtl/fifo_wide_unpacker.sv
// Drains wide FIFO words and serialises them into OUT_NUM-element beats.
// Optional prefetch next-word buffer: define FIFO_UNPACK_PREFETCH_EN.
module fifo_wide_unpacker #(
   parameter int INPUT_WIDTH = 8,
   parameter int INPUT_NUM   = 768,
   parameter int OUT_NUM     = 64
) (
   input  logic                             clk_p,
   input  logic                             rst,
   output logic                             fifo_read_en_n,
   input  logic [INPUT_WIDTH*INPUT_NUM-1:0] fifo_data,
   input  logic                             fifo_data_valid_n,
   output logic [INPUT_WIDTH*OUT_NUM-1:0]   out_data,
   output logic                             out_valid_n,
   input  logic                             out_ready_n,
   output logic                             out_last,
   output logic                             proto_err
);

   localparam int BEATS     = INPUT_NUM / OUT_NUM;
   localparam int OUT_WIDTH = INPUT_WIDTH * OUT_NUM;
   localparam int WORD_W    = INPUT_WIDTH * INPUT_NUM;
   localparam int CW        = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] SEND = 2'd3;

   generate
      if (INPUT_NUM % OUT_NUM != 0) begin : g_bad_ratio
         $error("INPUT_NUM must be a multiple of OUT_NUM");
      end
   endgenerate

   logic [1:0]        state_q;
   logic [CW-1:0]     beat_q;
   logic [WORD_W-1:0] buf_q;
   logic              rd_q;
   logic              err_q;
   logic              rd_en;
   logic              hs;
   logic              last_beat;
   logic              rsp_ok;

   assign last_beat = (beat_q == CW'(BEATS - 1));
   assign hs        = (state_q == SEND) && !out_ready_n;
   // rd_q marks the one cycle in which a response may legally arrive
   assign rsp_ok    = rd_q && !fifo_data_valid_n;

`ifdef FIFO_UNPACK_PREFETCH_EN
   logic [WORD_W-1:0] nxt_q;
   logic              nxt_full_q;

   assign rd_en = (state_q == REQ) ||
                  ((state_q == SEND) && !nxt_full_q && !rd_q);
`else
   assign rd_en = (state_q == REQ);
`endif

   assign fifo_read_en_n = !rd_en;
   assign out_valid_n    = (state_q != SEND);
   assign out_last       = (state_q == SEND) && last_beat;
   assign out_data       = buf_q[beat_q*OUT_WIDTH +: OUT_WIDTH];
   assign proto_err      = err_q;

   always_ff @(posedge clk_p) begin
      if (rst) begin
         state_q    <= IDLE;
         beat_q     <= '0;
         buf_q      <= '0;
         rd_q       <= 1'b0;
         err_q      <= 1'b0;
`ifdef FIFO_UNPACK_PREFETCH_EN
         nxt_q      <= '0;
         nxt_full_q <= 1'b0;
`endif
      end else begin
         rd_q <= rd_en;
         if (!fifo_data_valid_n && !rd_q)
            err_q <= 1'b1;
         unique case (state_q)
            IDLE: state_q <= REQ;
            REQ:  state_q <= WAIT;
            WAIT: begin
               if (rsp_ok) begin
                  buf_q   <= fifo_data;
                  beat_q  <= '0;
                  state_q <= SEND;
               end else begin
                  state_q <= REQ;
               end
            end
            SEND: begin
`ifdef FIFO_UNPACK_PREFETCH_EN
               if (rsp_ok && !(hs && last_beat)) begin
                  nxt_q      <= fifo_data;
                  nxt_full_q <= 1'b1;
               end
`endif
               if (hs) begin
                  if (!last_beat) begin
                     beat_q <= beat_q + 1'b1;
                  end else begin
                     beat_q <= '0;
`ifdef FIFO_UNPACK_PREFETCH_EN
                     if (nxt_full_q) begin
                        buf_q      <= nxt_q;
                        nxt_full_q <= rsp_ok;
                        if (rsp_ok)
                           nxt_q <= fifo_data;
                     end else if (rsp_ok) begin
                        buf_q <= fifo_data;
                     end else if (rd_en) begin
                        state_q <= WAIT;
                     end else begin
                        state_q <= REQ;
                     end
`else
                     state_q <= REQ;
`endif
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wide_unpacker.sv
// Directed bench for fifo_wide_unpacker with a small FIFO model.
// Honours FIFO_UNPACK_PREFETCH_EN for the gap and backpressure checks.
module tb_fifo_wide_unpacker;

   localparam int WW = 6144;
   localparam int OW = 512;

   logic          clk_p = 1'b0;
   logic          rst;
   logic          fifo_read_en_n;
   logic [WW-1:0] fifo_data;
   logic          fifo_data_valid_n;
   logic [OW-1:0] out_data;
   logic          out_valid_n;
   logic          out_ready_n;
   logic          out_last;
   logic          proto_err;

   int n_cmp = 0;
   int n_bad = 0;

   logic [WW-1:0] fifo_q[$];
   logic          rd_seen = 1'b0;
   logic          inj = 1'b0;

   fifo_wide_unpacker dut (
      .clk_p             (clk_p),
      .rst               (rst),
      .fifo_read_en_n    (fifo_read_en_n),
      .fifo_data         (fifo_data),
      .fifo_data_valid_n (fifo_data_valid_n),
      .out_data          (out_data),
      .out_valid_n       (out_valid_n),
      .out_ready_n       (out_ready_n),
      .out_last          (out_last),
      .proto_err         (proto_err)
   );

   always #5 clk_p = ~clk_p;

   // FIFO: a read seen in cycle t answers in cycle t+1
   always @(negedge clk_p) rd_seen = !fifo_read_en_n;

   always @(posedge clk_p) begin
      #1;
      if (inj) begin
         fifo_data         = '1;
         fifo_data_valid_n = 1'b0;
      end else if (rd_seen && fifo_q.size() != 0) begin
         fifo_data         = fifo_q.pop_front();
         fifo_data_valid_n = 1'b0;
      end else begin
         fifo_data_valid_n = 1'b1;
      end
   end

   function automatic logic [WW-1:0] mk_word(input int id);
      logic [WW-1:0] w;
      logic [7:0]    b;
      w = '0;
      for (int i = 0; i < 768; i++) begin
         b = 8'(i);
         w[8*i +: 8] = (id != 0) ? ~b : b;
      end
      return w;
   endfunction

   function automatic logic [OW-1:0] beat_exp(input int id, input int k);
      logic [OW-1:0] r;
      logic [7:0]    b;
      r = '0;
      for (int j = 0; j < 64; j++) begin
         b = 8'(64*k + j);
         r[8*j +: 8] = (id != 0) ? ~b : b;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [OW-1:0] got,
                      input logic [OW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_p);
   endtask

   task automatic wait_valid();
      int n = 0;
      while (out_valid_n && n < 12) begin
         tick();
         n++;
      end
      chk("wait_valid", OW'(out_valid_n), OW'(0));
   endtask

   task automatic drain();
      int n = 0;
      while (!(!out_valid_n && out_last) && n < 40) begin
         tick();
         n++;
      end
      chk("drain_last", OW'(out_last), OW'(1));
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt;
      int vbad;
      int gap;
      fifo_data         = '0;
      fifo_data_valid_n = 1'b1;
      rst               = 1'b1;
      out_ready_n       = 1'b0;
      fifo_q.push_back(mk_word(0));
      repeat (3) tick();

      chk("rst_rd_n", OW'(fifo_read_en_n), OW'(1));
      chk("rst_vld_n", OW'(out_valid_n), OW'(1));
      chk("rst_data", out_data, OW'(0));
      chk("rst_last", OW'(out_last), OW'(0));
      chk("rst_err", OW'(proto_err), OW'(0));

      // single word, full-rate drain
      rst = 1'b0;
      tick();
      chk("t1_rd_pulse", OW'(fifo_read_en_n), OW'(0));
      tick();
      chk("t1_wait_vld", OW'(out_valid_n), OW'(1));
      tick();
      chk("t1_first_vld", OW'(out_valid_n), OW'(0));
      for (int k = 0; k < 12; k++) begin
         chk($sformatf("t1_data%0d", k), out_data, beat_exp(0, k));
         chk($sformatf("t1_last%0d", k), OW'(out_last), OW'(k == 11));
         tick();
      end

      // empty FIFO: alternate-cycle retries
      cnt  = 0;
      vbad = 0;
      repeat (20) begin
         if (!fifo_read_en_n) cnt++;
         if (!out_valid_n) vbad++;
         tick();
      end
      chk("t2_pulses", OW'(cnt), OW'(10));
      chk("t2_no_vld", OW'(vbad), OW'(0));
      chk("t2_err", OW'(proto_err), OW'(0));

      // backpressure at beat 3
      fifo_q.push_back(mk_word(0));
      wait_valid();
      repeat (3) tick();
      out_ready_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("t3_hold_data", out_data, beat_exp(0, 3));
         chk("t3_hold_last", OW'(out_last), OW'(0));
`ifndef FIFO_UNPACK_PREFETCH_EN
         chk("t3_no_read", OW'(fifo_read_en_n), OW'(1));
`endif
         tick();
      end
      out_ready_n = 1'b0;
      chk("t3_still3", out_data, beat_exp(0, 3));
      tick();
      chk("t3_beat4", out_data, beat_exp(0, 4));
      drain();

      // two words back to back
      fifo_q.push_back(mk_word(0));
      fifo_q.push_back(mk_word(1));
      wait_valid();
      for (int k = 0; k < 12; k++) begin
         chk($sformatf("t4_a%0d", k), out_data, beat_exp(0, k));
         tick();
      end
      gap = 0;
      while (out_valid_n && gap < 10) begin
         gap++;
         tick();
      end
`ifdef FIFO_UNPACK_PREFETCH_EN
      chk("t4_gap", OW'(gap), OW'(0));
`else
      chk("t4_gap", OW'(gap), OW'(2));
`endif
      chk("t4_b0", out_data, beat_exp(1, 0));
      drain();

      // reset mid-word at beat 5
      fifo_q.push_back(mk_word(0));
      wait_valid();
      repeat (5) tick();
      chk("t5_beat5", out_data, beat_exp(0, 5));
      rst = 1'b1;
      tick();
      chk("t5_vld_n", OW'(out_valid_n), OW'(1));
      chk("t5_rd_n", OW'(fifo_read_en_n), OW'(1));
      chk("t5_last", OW'(out_last), OW'(0));
      fifo_q.push_back(mk_word(1));
      rst = 1'b0;
      tick();
      chk("t5_fresh_rd", OW'(fifo_read_en_n), OW'(0));
      tick();
      tick();
      chk("t5_new_vld", OW'(out_valid_n), OW'(0));
      chk("t5_new_b0", out_data, beat_exp(1, 0));
      drain();

`ifndef FIFO_UNPACK_PREFETCH_EN
      // stray valid during SEND
      out_ready_n = 1'b1;
      fifo_q.push_back(mk_word(0));
      wait_valid();
      inj = 1'b1;
      tick();
      inj = 1'b0;
      tick();
      chk("t6_err_set", OW'(proto_err), OW'(1));
      chk("t6_vld", OW'(out_valid_n), OW'(0));
      chk("t6_data", out_data, beat_exp(0, 0));
      out_ready_n = 1'b0;
      drain();
      chk("t6_err_sticky", OW'(proto_err), OW'(1));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_err_clr", OW'(proto_err), OW'(0));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fifo_wide_unpacker.md
Name: fifo_wide_unpacker

Overview:
- Read-side drain engine for the wide 8-FIFO buffer group.
- Pulses the FIFO read enable and captures each INPUT_WIDTH*INPUT_NUM-bit word.
- Serialises each word into OUT_NUM-element beats on an active-low valid/ready stream to downstream compute.
- Owns FIFO read timing, retries reads while the FIFO is empty, and applies downstream backpressure.

Parameters:
- INPUT_WIDTH, 8, bits per element.
- INPUT_NUM, 768, elements per FIFO word.
- OUT_NUM, 64, elements per output beat. INPUT_NUM % OUT_NUM != 0 is an elaboration error.
- BEATS, INPUT_NUM/OUT_NUM (12), beats per word (derived, not overridden).
- OUT_WIDTH, INPUT_WIDTH*OUT_NUM (512), beat width (derived).

Ports:
- clk_p  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- fifo_read_en_n  out  1  FIFO read request, active-low, one-cycle pulses.
- fifo_data  in  INPUT_WIDTH*INPUT_NUM  FIFO dout.
- fifo_data_valid_n  in  1  FIFO dout valid, active-low, one cycle after an accepted read.
- out_data  out  OUT_WIDTH  current beat.
- out_valid_n  out  1  beat valid, active-low.
- out_ready_n  in  1  downstream ready, active-low.
- out_last  out  1  high with the final beat of a word.
- proto_err  out  1  sticky error flag.

Behaviour:
- Reset: while rst=1, next edge sets:
  - state IDLE, beat_cnt 0, word buffer 0;
  - fifo_read_en_n 1, out_valid_n 1, out_data 0, out_last 0, proto_err 0.
- Reset mid-word discards the partial word; no beats are resumed.
- All outputs are driven from registers or a mux on registered state only; there is no combinational input-to-output path.
- FIFO contract: a read at edge t presents data with fifo_data_valid_n=0 at t+1. fifo_data_valid_n=1 in that cycle means the FIFO was empty, which is benign.
- States:
  - IDLE: leave for REQ on the first cycle with rst=0.
  - REQ: fifo_read_en_n=0 for exactly this cycle; go to WAIT.
  - WAIT: if fifo_data_valid_n=0, capture fifo_data into the buffer, set beat_cnt=0, go to SEND. Otherwise go to REQ. An empty FIFO therefore sees a read pulse every 2nd cycle.
  - SEND: out_valid_n=0. out_data = buffer[beat_cnt*OUT_WIDTH +: OUT_WIDTH], LSB-first, so beat 0 = elements 0..OUT_NUM-1. out_last = (beat_cnt==BEATS-1).
- SEND handshake fires when out_valid_n=0 and out_ready_n=0:
  - not the last beat: beat_cnt+1;
  - last beat: beat_cnt=0, go to REQ.
- Backpressure (out_ready_n=1): out_data, out_last and beat_cnt hold; no FIFO read is issued.
- Latency:
  - read pulse at t, first beat valid at t+2;
  - last handshake at t, next read pulse at t+1, next word's beat 0 at t+3 (2 bubble cycles).
- BEATS=1: every handshake is a last handshake.
- proto_err: set to 1 when fifo_data_valid_n=0 in any cycle that is not a read-response cycle. The data in that cycle is ignored. proto_err clears only on rst.

Optional Feature:
- Macro: FIFO_UNPACK_PREFETCH_EN.
- Defined: adds a next-word buffer and a next_full flag.
  - Read issue: in SEND, a read pulse is issued when next_full=0 and no response is pending from the previous cycle.
  - Response handling: a valid response sets next_full=1 and fills the next buffer. An invalid response is retried on the following cycle.
  - Source priority on the last-beat handshake:
    1. next buffer when next_full=1 (swap, clear next_full);
    2. a valid response arriving in that same cycle, loaded directly into the word buffer;
    3. otherwise WAIT if a read was pulsed that cycle, else REQ.
  - In cases 1 and 2, stay in SEND with beat_cnt=0, giving zero-bubble back-to-back words.
  - Read-response cycles for proto_err include prefetch responses.
- Undefined: base behaviour only; no next buffer; 2-cycle inter-word bubble.

Test Plan:
- Word ready, element i = i[7:0], out_ready_n=0 → read pulse at cycle 1 after rst falls, 12 consecutive beats, beat k bytes = 64k..64k+63, out_last only on beat 11.
- FIFO empty (fifo_data_valid_n held 1) for 20 cycles → fifo_read_en_n low on alternate cycles (10 pulses), out_valid_n stays 1, proto_err 0.
- out_ready_n=1 for 5 cycles at beat 3 → out_data = elements 192..255 stable all 5 cycles, beat_cnt 3, no read pulse; resumes at beat 4.
- Two words queued, ready=0:
  - macro off → exactly 2 cycles with out_valid_n=1 between beat 11 and the next beat 0;
  - macro on → 24 consecutive valid beats.
- rst pulsed 1 cycle during beat 5 → next cycle out_valid_n=1, fifo_read_en_n=1, out_last=0; after release, fresh read, and the new word's beat 0 is emitted.
- fifo_data_valid_n=0 injected during SEND (macro off) → proto_err=1 and stays 1, beat data unchanged, proto_err cleared only by rst.
